// File: rtl/ex_mem_elastic_pkg.sv
// Shared bubble constants and occupancy encoding for the EX/MEM elastic stage.
package ex_mem_elastic_pkg;

   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b01,
      OCC_FULL  = 2'b10
   } occ_t;

endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM entry register; clear (to bubble values) has priority over load.
module ex_mem_slot
   import ex_mem_elastic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [ADDR_W-1:0] nxt_wd,
   input  logic              nxt_wreg,
   input  logic [DATA_W-1:0] nxt_wdata,
   input  logic              nxt_whilo,
   input  logic [DATA_W-1:0] nxt_hi,
   input  logic [DATA_W-1:0] nxt_lo,
   output logic [ADDR_W-1:0] wd,
   output logic              wreg,
   output logic [DATA_W-1:0] wdata,
   output logic              whilo,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE || clear) begin
         wd    <= ADDR_W'(NOP_REG_ADDR);
         wreg  <= WRITE_DISABLE;
         wdata <= DATA_W'(ZERO_WORD);
         whilo <= WRITE_DISABLE;
         hi    <= DATA_W'(ZERO_WORD);
         lo    <= DATA_W'(ZERO_WORD);
      end else if (load) begin
         wd    <= nxt_wd;
         wreg  <= nxt_wreg;
         wdata <= nxt_wdata;
         whilo <= nxt_whilo;
         hi    <= nxt_hi;
         lo    <= nxt_lo;
      end
   end

endmodule

// File: rtl/ex_mem_elastic.sv
// EX/MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional backpressure counter port stall_cnt is built with EX_MEM_STALL_CNT_EN.
module ex_mem_elastic
   import ex_mem_elastic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_whilo,
   input  logic [DATA_W-1:0] ex_hi,
   input  logic [DATA_W-1:0] ex_lo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_whilo,
   output logic [DATA_W-1:0] mem_hi,
   output logic [DATA_W-1:0] mem_lo
`ifdef EX_MEM_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   occ_t state, state_nxt;
   logic accept, drain;
   logic main_load, skid_load, main_from_skid;

   logic [ADDR_W-1:0] main_wd, skid_wd, main_nxt_wd;
   logic              main_wreg, skid_wreg, main_nxt_wreg;
   logic [DATA_W-1:0] main_wdata, skid_wdata, main_nxt_wdata;
   logic              main_whilo, skid_whilo, main_nxt_whilo;
   logic [DATA_W-1:0] main_hi, skid_hi, main_nxt_hi;
   logic [DATA_W-1:0] main_lo, skid_lo, main_nxt_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) state <= OCC_EMPTY;
      else                   state <= state_nxt;
   end

   always_comb begin
      accept         = in_valid & in_ready;
      drain          = out_valid & out_ready;
      state_nxt      = state;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      unique case (state)
         OCC_EMPTY: if (accept) begin
            main_load = 1'b1;
            state_nxt = OCC_ONE;
         end
         OCC_ONE: begin
            if (accept && drain) begin
               main_load = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
               state_nxt = OCC_FULL;
            end else if (drain) begin
               state_nxt = OCC_EMPTY;
            end
         end
         OCC_FULL: if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = OCC_ONE;
         end
         default: state_nxt = OCC_EMPTY;
      endcase
      // Loads are harmless under flush: the slots give clear priority.
      if (flush) state_nxt = OCC_EMPTY;
   end

   // Both handshake outputs decode registered state only, so no comb path from out_ready.
   always_comb begin
      in_ready  = (state != OCC_FULL);
      out_valid = (state != OCC_EMPTY);
   end

   always_comb begin
      main_nxt_wd    = main_from_skid ? skid_wd    : ex_wd;
      main_nxt_wreg  = main_from_skid ? skid_wreg  : ex_wreg;
      main_nxt_wdata = main_from_skid ? skid_wdata : ex_wdata;
      main_nxt_whilo = main_from_skid ? skid_whilo : ex_whilo;
      main_nxt_hi    = main_from_skid ? skid_hi    : ex_hi;
      main_nxt_lo    = main_from_skid ? skid_lo    : ex_lo;
   end

   ex_mem_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
      .clk(clk), .rst(rst), .load(main_load), .clear(flush),
      .nxt_wd(main_nxt_wd), .nxt_wreg(main_nxt_wreg), .nxt_wdata(main_nxt_wdata),
      .nxt_whilo(main_nxt_whilo), .nxt_hi(main_nxt_hi), .nxt_lo(main_nxt_lo),
      .wd(main_wd), .wreg(main_wreg), .wdata(main_wdata),
      .whilo(main_whilo), .hi(main_hi), .lo(main_lo)
   );

   ex_mem_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
      .clk(clk), .rst(rst), .load(skid_load), .clear(flush),
      .nxt_wd(ex_wd), .nxt_wreg(ex_wreg), .nxt_wdata(ex_wdata),
      .nxt_whilo(ex_whilo), .nxt_hi(ex_hi), .nxt_lo(ex_lo),
      .wd(skid_wd), .wreg(skid_wreg), .wdata(skid_wdata),
      .whilo(skid_whilo), .hi(skid_hi), .lo(skid_lo)
   );

   always_comb begin
      mem_wd    = main_wd;
      mem_wreg  = main_wreg & out_valid;
      mem_wdata = main_wdata;
      mem_whilo = main_whilo & out_valid;
      mem_hi    = main_hi;
      mem_lo    = main_lo;
   end

`ifdef EX_MEM_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE)          stall_cnt <= '0;
      else if (out_valid & ~out_ready) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Scoreboard bench for ex_mem_elastic: a queue model predicts occupancy and FIFO order.
module tb_ex_mem_elastic;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic [DATA_W-1:0] wdata;
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [ADDR_W-1:0] ex_wd, mem_wd;
   logic              ex_wreg, ex_whilo, mem_wreg, mem_whilo;
   logic [DATA_W-1:0] ex_wdata, ex_hi, ex_lo, mem_wdata, mem_hi, mem_lo;
`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   entry_t      exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   int unsigned exp_stall = 0;
   entry_t      idle = '0;

   always #5 clk = ~clk;

   ex_mem_elastic #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .out_valid(out_valid), .out_ready(out_ready),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo)
`ifdef EX_MEM_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic entry_t mk(input int unsigned wd, input logic wreg, input logic [DATA_W-1:0] wdata);
      entry_t e;
      e.wd    = ADDR_W'(wd);
      e.wreg  = wreg;
      e.wdata = wdata;
      e.whilo = 1'b1;
      e.hi    = ~wdata;
      e.lo    = wdata ^ 32'h5A5A_5A5A;
      return e;
   endfunction

   function automatic entry_t rnd();
      entry_t e;
      e.wd    = ADDR_W'($urandom);
      e.wreg  = 1'($urandom);
      e.wdata = $urandom;
      e.whilo = 1'($urandom);
      e.hi    = $urandom;
      e.lo    = $urandom;
      return e;
   endfunction

   // Called at posedge+1; the model updates at the next posedge, where the DUT transfers.
   task automatic drive(input bit v, input bit fl, input bit ordy, input entry_t e, output bit acc);
      bit pred_ready;
      pred_ready = exp_q.size() < 2;
      in_valid = v; flush = fl; out_ready = ordy;
      ex_wd = e.wd; ex_wreg = e.wreg; ex_wdata = e.wdata;
      ex_whilo = e.whilo; ex_hi = e.hi; ex_lo = e.lo;
      @(posedge clk);
      if (exp_q.size() > 0 && !ordy) exp_stall++;
      acc = 1'b0;
      if (fl) exp_q.delete();
      else if (v && pred_ready) begin
         exp_q.push_back(e);
         acc = 1'b1;
      end
      #1;
   endtask

   task automatic step(input bit v, input bit fl, input bit ordy, input entry_t e);
      bit acc;
      drive(v, fl, ordy, e, acc);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      exp_stall = 0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_mem_wd", mem_wd, 0);
      check("rst_mem_wreg", mem_wreg, 0);
      check("rst_mem_whilo", mem_whilo, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_hi", mem_hi, 0);
      check("rst_mem_lo", mem_lo, 0);
`ifdef EX_MEM_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      #1 mon_en = 1'b1;
   endtask

   // Monitor: compares presented entry against queue head; pops on a non-flushed drain.
   initial forever begin : monitor
      entry_t h;
      bit     ev;
      @(negedge clk);
      if (mon_en) begin
         ev = exp_q.size() > 0;
         check("out_valid", out_valid, ev);
         check("in_ready", in_ready, exp_q.size() < 2);
         if (!ev) begin
            check("bubble_wreg", mem_wreg, 0);
            check("bubble_whilo", mem_whilo, 0);
         end else begin
            h = exp_q[0];
            check("mem_wd", mem_wd, h.wd);
            check("mem_wreg", mem_wreg, h.wreg);
            check("mem_wdata", mem_wdata, h.wdata);
            check("mem_whilo", mem_whilo, h.whilo);
            check("mem_hi", mem_hi, h.hi);
            check("mem_lo", mem_lo, h.lo);
            if (out_ready && !flush) void'(exp_q.pop_front());
         end
`ifdef EX_MEM_STALL_CNT_EN
         check("stall_cnt", stall_cnt, exp_stall);
`endif
      end
   end

   initial begin : stimulus
      bit acc;
      do_reset();

      // Single pass-through
      step(1, 0, 1, mk(3, 1, 32'hDEAD_BEEF));
      step(0, 0, 1, idle);
      step(0, 0, 1, idle);

      // Backpressure: A, B fill both slots, C must wait
      step(1, 0, 0, mk(1, 1, 32'h1));
      step(1, 0, 0, mk(2, 1, 32'h2));
      step(1, 0, 0, mk(4, 1, 32'h3));
      step(1, 0, 0, mk(4, 1, 32'h3));
      acc = 1'b0;
      for (int i = 0; i < 4 && !acc; i++) drive(1, 0, 1, mk(4, 1, 32'h3), acc);
      check("c_accepted", acc, 1);
      repeat (3) step(0, 0, 1, idle);

      // Streaming
      for (int i = 0; i < 8; i++) step(1, 0, 1, mk(i + 8, 1, 32'(i)));
      repeat (2) step(0, 0, 1, idle);

      // Flush while FULL with a new input
      step(1, 0, 0, mk(10, 1, 32'hA));
      step(1, 0, 0, mk(11, 1, 32'hB));
      step(1, 1, 0, mk(12, 1, 32'hC));
      repeat (3) step(0, 0, 1, idle);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 6), rnd());
      repeat (4) step(0, 0, 1, idle);

      // Async reset mid-transfer
      step(1, 0, 0, rnd());
      step(1, 0, 0, rnd());
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_in_ready", in_ready, 1);
      check("async_mem_wreg", mem_wreg, 0);
      check("async_mem_wdata", mem_wdata, 0);
      do_reset();

`ifdef EX_MEM_STALL_CNT_EN
      step(1, 0, 0, mk(7, 1, 32'h77));
      repeat (10) step(0, 0, 0, idle);
      check("stall_cnt_10", stall_cnt, 10);
      repeat (3) step(0, 0, 0, idle);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("stall_cnt_async_rst", stall_cnt, 0);
      do_reset();
`endif

      step(0, 0, 1, idle);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
